// File: rtl/hazard_scoreboard.sv
// Purpose : per-register scoreboard for the in-order pipeline; decides decode stalls
//           and the forwarding source (producer age, 0 = register file) of each operand.
// Latency : stall/issue_ok/fwd_sel are combinational; entry state updates one edge after issue.
// Backpressure: stall=1 holds decode and sends a bubble to EX; in-flight entries keep ageing.
//
// Ports: clk, rst (sync, active-low); issue_* describe the instruction in decode;
//        flush kills the decode instruction this cycle; halt clears all tracking;
//        stall, issue_ok, fwd_sel1/2 (producer age per source), stall_cnt (saturating).
module hazard_scoreboard #(
  parameter int NREG     = 8,
  parameter int DEPTH    = 3,
  parameter int ZERO_REG = 0,
  parameter int CW       = 16,
  localparam int AW      = $clog2(NREG),
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic          issue_rs1_used,
  input  logic          issue_rs2_used,
  input  logic          issue_wr_en,
  input  logic [AW-1:0] issue_wr_reg,
  input  logic [DW-1:0] issue_lat,
  input  logic          flush,
  input  logic          halt,
  output logic          stall,
  output logic [DW-1:0] fwd_sel1,
  output logic [DW-1:0] fwd_sel2,
  output logic          issue_ok,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_D   = DW'(1);

  // Entry state: age counts stages since issue (1 = EX .. DEPTH = WB),
  // lat is the age at which the result first becomes forwardable.
  logic [NREG-1:0] busy_q;
  logic [DW-1:0]   age_q [NREG];
  logic [DW-1:0]   lat_q [NREG];

  logic [DW-1:0] lat_clamped;
  logic          live1, live2;
  logic          hazard1, hazard2;
  logic          gate;

  // Register 0 is never tracked when it is hardwired.
  function automatic logic tracked(input logic [AW-1:0] r);
    return (ZERO_REG == 0) || (r != '0);
  endfunction

  always_comb begin
    lat_clamped = issue_lat;
    if (issue_lat == '0) begin
      lat_clamped = ONE_D;
    end else if (issue_lat > DEPTH_D) begin
      lat_clamped = DEPTH_D;
    end
  end

  // Hazards look only at registered state, so an instruction that reads and
  // writes the same register is checked against the previous writer.
  always_comb begin
    live1    = issue_rs1_used & busy_q[issue_rs1] & tracked(issue_rs1);
    live2    = issue_rs2_used & busy_q[issue_rs2] & tracked(issue_rs2);
    hazard1  = live1 & (age_q[issue_rs1] < lat_q[issue_rs1]);
    hazard2  = live2 & (age_q[issue_rs2] < lat_q[issue_rs2]);
    gate     = issue_valid & ~flush & ~halt;
    stall    = gate & (hazard1 | hazard2);
    issue_ok = gate & ~(hazard1 | hazard2);
    fwd_sel1 = (live1 & ~hazard1) ? age_q[issue_rs1] : '0;
    fwd_sel2 = (live2 & ~hazard2) ? age_q[issue_rs2] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q    <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        age_q[i] <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      if (halt) begin
        busy_q <= '0;
      end else begin
        // Downstream stages advance even while decode stalls.
        for (int i = 0; i < NREG; i++) begin
          if (busy_q[i]) begin
            if (age_q[i] == DEPTH_D) begin
              busy_q[i] <= 1'b0;
            end else begin
              age_q[i] <= age_q[i] + ONE_D;
            end
          end
        end
        // Placed after the ageing loop so the youngest writer overrides
        // both ageing and a same-edge retire of that register.
        if (issue_ok && issue_wr_en && tracked(issue_wr_reg)) begin
          busy_q[issue_wr_reg] <= 1'b1;
          age_q[issue_wr_reg]  <= ONE_D;
          lat_q[issue_wr_reg]  <= lat_clamped;
        end
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_rs1 = '0, issue_rs2 = '0, issue_wr_reg = '0;
  logic       issue_rs1_used = 1'b0, issue_rs2_used = 1'b0, issue_wr_en = 1'b0;
  logic [1:0] issue_lat = '0;
  logic       flush = 1'b0, halt = 1'b0;

  logic        stall_a, ok_a, stall_b, ok_b;
  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: hardwired r0 and a narrow stall counter.
  hazard_scoreboard dut_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg), .issue_lat(issue_lat),
    .flush(flush), .halt(halt), .stall(stall_a), .fwd_sel1(f1_a), .fwd_sel2(f2_a),
    .issue_ok(ok_a), .stall_cnt(cnt_a)
  );

  hazard_scoreboard #(.ZERO_REG(1), .CW(4)) dut_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg), .issue_lat(issue_lat),
    .flush(flush), .halt(halt), .stall(stall_b), .fwd_sel1(f1_b), .fwd_sel2(f2_b),
    .issue_ok(ok_b), .stall_cnt(cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Timestamp model: each register remembers the cycle of its youngest accepted
  // writer and that writer's latency; age is simply elapsed cycles.
  int cyc = 0;
  bit model_ok = 1'b0;
  int last_t [2][8];
  int last_l [2][8];
  int mcnt   [2];

  function automatic bit trk(input int k, input int r);
    return !(k == 1 && r == 0);
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic void model_eval(input int k, output int st, output int ok,
                                     output int f1, output int f2);
    int d1, d2;
    bit l1, l2, h1, h2, g;
    d1 = cyc - last_t[k][issue_rs1];
    d2 = cyc - last_t[k][issue_rs2];
    l1 = issue_rs1_used && trk(k, int'(issue_rs1)) && d1 >= 1 && d1 <= DEPTH;
    l2 = issue_rs2_used && trk(k, int'(issue_rs2)) && d2 >= 1 && d2 <= DEPTH;
    h1 = l1 && (d1 < last_l[k][issue_rs1]);
    h2 = l2 && (d2 < last_l[k][issue_rs2]);
    g  = issue_valid && !flush && !halt;
    st = (g && (h1 || h2)) ? 1 : 0;
    ok = (g && !(h1 || h2)) ? 1 : 0;
    f1 = (l1 && !h1) ? d1 : 0;
    f2 = (l2 && !h2) ? d2 : 0;
  endfunction

  always @(posedge clk) begin
    int st, ok, f1, f2, lt;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, st, ok, f1, f2);
      if (!rst) begin
        for (int r = 0; r < 8; r++) last_t[k][r] = -1000;
        mcnt[k] = 0;
      end else if (halt) begin
        for (int r = 0; r < 8; r++) last_t[k][r] = -1000;
      end else begin
        if (st != 0 && mcnt[k] < cmax(k)) mcnt[k]++;
        if (ok != 0 && issue_wr_en && trk(k, int'(issue_wr_reg))) begin
          lt = int'(issue_lat);
          if (lt == 0) lt = 1;
          if (lt > DEPTH) lt = DEPTH;
          last_t[k][issue_wr_reg] = cyc;
          last_l[k][issue_wr_reg] = lt;
        end
      end
    end
    if (!rst) model_ok = 1'b1;
    cyc++;
  end

  // Every-cycle comparison against the model; forwarding only matters when not stalling.
  always @(negedge clk) begin
    int st, ok, f1, f2;
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        model_eval(k, st, ok, f1, f2);
        chk($sformatf("c%0d i%0d stall", cyc, k), int'(k == 0 ? stall_a : stall_b), st);
        chk($sformatf("c%0d i%0d issue_ok", cyc, k), int'(k == 0 ? ok_a : ok_b), ok);
        chk($sformatf("c%0d i%0d stall_cnt", cyc, k), k == 0 ? int'(cnt_a) : int'(cnt_b), mcnt[k]);
        if (st == 0) begin
          chk($sformatf("c%0d i%0d fwd_sel1", cyc, k), int'(k == 0 ? f1_a : f1_b), f1);
          chk($sformatf("c%0d i%0d fwd_sel2", cyc, k), int'(k == 0 ? f2_a : f2_b), f2);
        end
      end
    end
  end

  // One decode cycle: set inputs after the edge, return once they have settled.
  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input bit we, input int wr, input int lt,
                       input bit fl = 1'b0, input bit hl = 1'b0);
    @(posedge clk);
    #1;
    issue_valid    = v;
    issue_rs1      = r1[2:0];
    issue_rs1_used = u1;
    issue_rs2      = r2[2:0];
    issue_rs2_used = u2;
    issue_wr_en    = we;
    issue_wr_reg   = wr[2:0];
    issue_lat      = lt[1:0];
    flush          = fl;
    halt           = hl;
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rd(input int r);
    drive(1, r, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic wr(input int r, input int lt, input bit fl = 1'b0);
    drive(1, 0, 0, 0, 0, 1, r, lt, fl);
  endtask

  initial begin
    // Reset
    nop();
    nop();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(3);
    chk("reset_stall", int'(stall_a), 0);
    chk("reset_fwd1", int'(f1_a), 0);
    chk("reset_issue_ok", int'(ok_a), 1);
    chk("reset_cnt", int'(cnt_a), 0);

    // ALU chain: producer visible at ages 1,2,3 then gone
    wr(3, 1);
    rd(3); chk("alu_c1_fwd", int'(f1_a), 1); chk("alu_c1_stall", int'(stall_a), 0);
    rd(3); chk("alu_c2_fwd", int'(f1_a), 2);
    rd(3); chk("alu_c3_fwd", int'(f1_a), 3);
    rd(3); chk("alu_c4_fwd", int'(f1_a), 0);

    // Load-use: one stall, then forward from age 2
    wr(2, 2);
    rd(2); chk("lu_stall", int'(stall_a), 1); chk("lu_issue_ok", int'(ok_a), 0);
    rd(2); chk("lu_held_stall", int'(stall_a), 0); chk("lu_held_fwd", int'(f1_a), 2);
    chk("lu_cnt", int'(cnt_a), 1);

    // WAW: younger load-latency writer governs; rs1==rs2 gives identical selects
    wr(5, 1);
    wr(5, 2);
    drive(1, 5, 1, 5, 1, 0, 0, 1); chk("waw_stall", int'(stall_a), 1);
    drive(1, 5, 1, 5, 1, 0, 0, 1);
    chk("waw_stall2", int'(stall_a), 0);
    chk("waw_fwd1", int'(f1_a), 2);
    chk("waw_fwd2", int'(f2_a), 2);

    // Flush suppresses the write; halt clears tracking
    wr(4, 1, 1'b1); chk("flush_issue_ok", int'(ok_a), 0);
    rd(4); chk("flush_fwd", int'(f1_a), 0);
    wr(6, 1);
    drive(1, 6, 1, 0, 0, 0, 0, 1, 1'b0, 1'b1);
    chk("halt_issue_ok", int'(ok_a), 0);
    chk("halt_stall", int'(stall_a), 0);
    rd(6);
    chk("halt_fwd", int'(f1_a), 0);
    chk("halt_stall_after", int'(stall_a), 0);
    chk("halt_cnt", int'(cnt_a), 2);

    // Register 0: tracked on instance 0, hardwired on instance 1
    wr(0, 2);
    rd(0);
    chk("r0_a_stall", int'(stall_a), 1);
    chk("r0_b_stall", int'(stall_b), 0);
    chk("r0_b_fwd", int'(f1_b), 0);
    chk("r0_b_ok", int'(ok_b), 1);
    rd(0); chk("r0_a_fwd", int'(f1_a), 2);

    // Self-dependent lat-3 instruction: two stalls per three cycles
    for (int i = 0; i < 36; i++) drive(1, 1, 1, 0, 0, 1, 1, 3);
    nop();
    chk("sat_b_cnt", int'(cnt_b), 15);
    chk("sat_a_cnt", int'(cnt_a), 27);

    // Reset in flight drops the pending lat-3 producer
    wr(7, 3);
    nop();
    rst = 1'b0;
    rd(7);
    rst = 1'b1;
    chk("midrst_stall", int'(stall_a), 0);
    chk("midrst_fwd", int'(f1_a), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    nop();
    nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard and hazard controller for the in-order pipeline. It sits between decode and the DEC/EX pipeline register. It tracks every in-flight register write by age and producer latency. Each cycle it tells decode whether the current instruction must stall and where each source operand must be forwarded from. It generalises the fixed single-cycle load-use check to any register count, pipeline depth and per-instruction result latency, and adds WAW tracking, flush/halt handling and a stall counter.

## Interface
- NREG, 8: architectural register count, ≥2.
- DEPTH, 3: issue-to-writeback distance in stages. Age 1 = EX, age DEPTH = WB.
- ZERO_REG, 0: 1 = register 0 is hardwired and never tracked.
- CW, 16: stall counter width.
- Derived: AW = clog2(NREG), DW = clog2(DEPTH+1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode holds a real instruction this cycle.
- issue_rs1, issue_rs2  in  AW  source register numbers.
- issue_rs1_used, issue_rs2_used  in  1  the source is actually read.
- issue_wr_en  in  1  the instruction writes a register.
- issue_wr_reg  in  AW  destination register.
- issue_lat  in  DW  cycles after issue until the result is forwardable. ALU = 1, load = 2.
- flush  in  1  kill the instruction currently in decode (taken branch/jump in EX).
- halt  in  1  pipeline halt. Clears all tracking.
- stall  out  1  decode must hold and a bubble is sent to EX.
- fwd_sel1, fwd_sel2  out  DW  age of the producing stage for each source. 0 = register file.
- issue_ok  out  1  the instruction is issued this cycle.
- stall_cnt  out  CW  saturating count of stall cycles.

## Operation
- Per-register entry holds: busy, age (DW bits), lat (DW bits).
- issue_lat is clamped: 0 becomes 1, and values above DEPTH become DEPTH.
- Hazard for a source s: `used_s & busy[r_s] & age[r_s] < lat[r_s]`, where r_s is that source's register number.
  - With ZERO_REG=1, r_s==0 never hazards.
- stall = `issue_valid & ~flush & ~halt & (hazard1 | hazard2)`. This is combinational from registered state and inputs.
- issue_ok = `issue_valid & ~flush & ~halt & ~stall`.
- fwd_selN = `age[r_s]` when `used_s & busy[r_s] & ~hazard`, else 0. It is valid whenever stall=0.
- Per-cycle update of every busy entry:
  - age increments by 1.
  - The entry clears when age==DEPTH. It stays visible through WB, then retires.
- On issue_ok & issue_wr_en, with issue_wr_reg tracked:
  - The entry is loaded with busy=1, age=1, lat=clamped issue_lat.
  - This overrides the ageing/retire update for that register, so the youngest writer always wins (WAW).
- A stall inserts no entry. Existing entries keep ageing, because downstream stages still advance.
- flush suppresses issue for that cycle only. Existing entries are unaffected; older instructions are already committed to the pipeline.
- halt: on the next edge all busy bits clear and stall_cnt is held. It has priority over issue.
- stall_cnt increments on each cycle with stall=1 and saturates at 2^CW−1.

## Timing
- Reset (rst=0 at an edge): all entries are non-busy and stall_cnt=0. As a result stall=0, fwd_sel1/2=0 and issue_ok=issue_valid&~flush&~halt in the following cycles.
- Reset mid-operation drops all in-flight tracking within the same edge.
- stall, fwd_sel and issue_ok have zero latency. They are combinational and settle within the cycle decode presents the instruction.
- Entry state changes one edge after issue.
- The producer is visible with fwd_sel = 1..DEPTH on cycles t+1..t+DEPTH after issue at t, and is gone at t+DEPTH+1.
- A dependent instruction with producer latency L stalls for exactly max(0, L−d) cycles, where d is the issue distance in cycles.
- If rs1==rs2, both outputs are identical.
- If rs==wr_reg of the current instruction, the hazard is evaluated against the prior entry only.
- Simultaneous retire and re-issue of the same register: the new entry wins.
- If flush and halt are asserted together, halt wins.

## Test plan
- Reset: hold rst=0 two cycles, then issue read r3 -> stall=0, fwd_sel1=0, issue_ok=1, stall_cnt=0.
- ALU chain: cycle 0 issue wr r3 lat1; cycles 1–4 issue read r3 -> stall=0 each cycle, fwd_sel1 = 1, 2, 3, then 0.
- Load-use: cycle 0 wr r2 lat2; cycle 1 read r2 -> stall=1, issue_ok=0; cycle 2, same instruction held -> stall=0, fwd_sel1=2; stall_cnt=1.
- WAW: c0 wr r5 lat1, c1 wr r5 lat2, c2 read r5 -> stall=1; c3 -> stall=0, fwd_sel1=2 (the younger writer).
- Flush/halt: c0 wr r4 with flush=1 -> c1 read r4 gives fwd_sel1=0. Then wr r6, halt for one cycle -> next read r6 gives fwd_sel1=0, stall=0.
- ZERO_REG=1: wr r0 lat2, then read r0 -> stall=0, fwd_sel1=0. Then force 2^CW+3 stalls -> stall_cnt saturates at 2^CW−1.
